// File: rtl/uart_counter_axil_slave.sv
// AXI4-Lite register file for the UART counter IP: four 32-bit byte-strobed registers in slots 0-3.
// Optional macro UART_CNT_AXIL_SLVERR_EN: accesses to unmapped slots 4-7 answer SLVERR instead of OKAY.
`timescale 1ns/1ps

module uart_counter_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]                      AWPROT,
    input  logic                            AWVALID,
    output logic                            AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                            WVALID,
    output logic                            WREADY,
    output logic [1:0]                      BRESP,
    output logic                            BVALID,
    input  logic                            BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]                      ARPROT,
    input  logic                            ARVALID,
    output logic                            ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                      RRESP,
    output logic                            RVALID,
    input  logic                            RREADY,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0] regs_o,
    output logic [3:0]                      wr_pulse_o
);

    localparam int DW        = C_S_AXI_DATA_WIDTH;
    localparam int NUM_BYTES = DW / 8;
    localparam int NUM_SLOTS = 4;
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef UART_CNT_AXIL_SLVERR_EN
    localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
    localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

    logic                 ready_en_reg;
    logic                 aw_full_reg;
    logic [2:0]           aw_slot_reg;
    logic                 w_full_reg;
    logic [DW-1:0]        w_data_reg;
    logic [NUM_BYTES-1:0] w_strb_reg;
    logic                 bvalid_reg;
    logic [1:0]           bresp_reg;
    logic                 rvalid_reg;
    logic [DW-1:0]        rdata_reg;
    logic [1:0]           rresp_reg;

    logic                 aw_hs;
    logic                 w_hs;
    logic                 ar_hs;
    logic                 commit;
    logic                 commit_mapped;
    logic [2:0]           ar_slot;
    logic [DW-1:0]        rd_word;
    logic [DW-1:0]        slot_words [NUM_SLOTS];
    logic                 unused_bits;

    assign unused_bits = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

    // Ready outputs stay low through reset and rise one edge after release.
    assign AWREADY = ready_en_reg & ~aw_full_reg & ~bvalid_reg;
    assign WREADY  = ready_en_reg & ~w_full_reg & ~bvalid_reg;
    assign ARREADY = ready_en_reg & ~rvalid_reg;

    assign aw_hs         = AWVALID & AWREADY;
    assign w_hs          = WVALID & WREADY;
    assign ar_hs         = ARVALID & ARREADY;
    assign commit        = aw_full_reg & w_full_reg;
    assign commit_mapped = commit & ~aw_slot_reg[2];
    assign ar_slot       = ARADDR[4:2];

    assign BVALID = bvalid_reg;
    assign BRESP  = bresp_reg;
    assign RVALID = rvalid_reg;
    assign RDATA  = rdata_reg;
    assign RRESP  = rresp_reg;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
        end
    end

    // Address and data latch independently; the commit fires once both are held.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_full_reg <= 1'b0;
            aw_slot_reg <= '0;
            w_full_reg  <= 1'b0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_full_reg <= 1'b1;
                aw_slot_reg <= AWADDR[4:2];
            end else if (commit) begin
                aw_full_reg <= 1'b0;
            end
            if (w_hs) begin
                w_full_reg <= 1'b1;
                w_data_reg <= WDATA;
                w_strb_reg <= WSTRB;
            end else if (commit) begin
                w_full_reg <= 1'b0;
            end
            if (commit) begin
                bvalid_reg <= 1'b1;
                bresp_reg  <= aw_slot_reg[2] ? RESP_UNMAPPED : RESP_OKAY;
            end else if (bvalid_reg && BREADY) begin
                bvalid_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (!ar_slot[2]) begin
            rd_word = slot_words[ar_slot[1:0]];
        end
    end

    // Reads sample the pre-commit register value when both happen on the same edge.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
            rresp_reg  <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= rd_word;
                rresp_reg  <= ar_slot[2] ? RESP_UNMAPPED : RESP_OKAY;
            end else if (rvalid_reg && RREADY) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            logic          slot_wr;
            logic [DW-1:0] slot_reg;
            logic          pulse_reg;

            assign slot_wr = commit_mapped && (aw_slot_reg[1:0] == 2'(gi));

            always_ff @(posedge ACLK or posedge ARESET) begin
                if (ARESET) begin
                    slot_reg  <= '0;
                    pulse_reg <= 1'b0;
                end else begin
                    pulse_reg <= slot_wr;
                    if (slot_wr) begin
                        for (int b = 0; b < NUM_BYTES; b++) begin
                            if (w_strb_reg[b]) begin
                                slot_reg[8*b +: 8] <= w_data_reg[8*b +: 8];
                            end
                        end
                    end
                end
            end

            assign slot_words[gi]        = slot_reg;
            assign regs_o[DW*gi +: DW]   = slot_reg;
            assign wr_pulse_o[gi]        = pulse_reg;
        end
    endgenerate

endmodule

// File: tb/tb_uart_counter_axil_slave.sv
// Self-checking bench for uart_counter_axil_slave: vector table plus hand-written corner sequences,
// with B/R responses checked against scoreboard queues by a negedge monitor.
`timescale 1ns/1ps

module tb_uart_counter_axil_slave;

    logic         ACLK = 1'b0;
    logic         ARESET = 1'b1;
    logic [4:0]   AWADDR = '0;
    logic [2:0]   AWPROT = '0;
    logic         AWVALID = 1'b0;
    logic         AWREADY;
    logic [31:0]  WDATA = '0;
    logic [3:0]   WSTRB = '0;
    logic         WVALID = 1'b0;
    logic         WREADY;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY = 1'b0;
    logic [4:0]   ARADDR = '0;
    logic [2:0]   ARPROT = '0;
    logic         ARVALID = 1'b0;
    logic         ARREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RVALID;
    logic         RREADY = 1'b0;
    logic [127:0] regs_o;
    logic [3:0]   wr_pulse_o;

`ifdef UART_CNT_AXIL_SLVERR_EN
    localparam logic [1:0] UNMAP_RESP = 2'b10;
`else
    localparam logic [1:0] UNMAP_RESP = 2'b00;
`endif

    always #5 ACLK = ~ACLK;

    uart_counter_axil_slave dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .AWADDR     (AWADDR),
        .AWPROT     (AWPROT),
        .AWVALID    (AWVALID),
        .AWREADY    (AWREADY),
        .WDATA      (WDATA),
        .WSTRB      (WSTRB),
        .WVALID     (WVALID),
        .WREADY     (WREADY),
        .BRESP      (BRESP),
        .BVALID     (BVALID),
        .BREADY     (BREADY),
        .ARADDR     (ARADDR),
        .ARPROT     (ARPROT),
        .ARVALID    (ARVALID),
        .ARREADY    (ARREADY),
        .RDATA      (RDATA),
        .RRESP      (RRESP),
        .RVALID     (RVALID),
        .RREADY     (RREADY),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o)
    );

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    localparam int NVEC = 19;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mdl [4];
    logic [1:0]  b_q [$];
    logic [33:0] r_q [$];
    int          pulse_cnt [4];
    vec_t        vecs [NVEC];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [4:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input logic [31:0] exp_data,
                                input logic [1:0] exp_resp);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.strb = strb;
        v.exp_data = exp_data; v.exp_resp = exp_resp;
        return v;
    endfunction

    task automatic model_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        if (!addr[4]) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mdl[addr[3:2]][8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    function automatic logic [127:0] model_flat();
        return {mdl[3], mdl[2], mdl[1], mdl[0]};
    endfunction

    // Scoreboard monitor: response handshakes are compared against queued expectations.
    always @(negedge ACLK) begin
        logic [1:0]  eb;
        logic [33:0] er;
        if (!ARESET) begin
            for (int k = 0; k < 4; k++) pulse_cnt[k] += int'(wr_pulse_o[k]);
            if (BVALID && BREADY) begin
                if (b_q.size() == 0) chk("b_unexpected", 1, 0);
                else begin
                    eb = b_q.pop_front();
                    chk("bresp", BRESP, eb);
                    $display("B  resp=%0b exp=%0b", BRESP, eb);
                end
            end
            if (RVALID && RREADY) begin
                if (r_q.size() == 0) chk("r_unexpected", 1, 0);
                else begin
                    er = r_q.pop_front();
                    chk("rdata", RDATA, er[33:2]);
                    chk("rresp", RRESP, er[1:0]);
                    $display("R  data=%08h resp=%0b exp=%08h/%0b", RDATA, RRESP, er[33:2], er[1:0]);
                end
            end
        end
    end

    // Tasks are entered and left 1ns after a rising edge.
    task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] exp_resp);
        logic a, w, aw_done, w_done, b_done;
        b_q.push_back(exp_resp);
        model_write(addr, data, strb);
        $display("W  addr=%02h data=%08h strb=%04b", addr, data, strb);
        AWADDR = addr; AWVALID = 1'b1;
        WDATA = data; WSTRB = strb; WVALID = 1'b1;
        BREADY = 1'b1;
        aw_done = 1'b0; w_done = 1'b0;
        for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
            @(negedge ACLK);
            a = AWVALID && AWREADY;
            w = WVALID && WREADY;
            @(posedge ACLK); #1;
            if (a) begin AWVALID = 1'b0; aw_done = 1'b1; end
            if (w) begin WVALID = 1'b0; w_done = 1'b1; end
        end
        if (!(aw_done && w_done)) chk("wr_handshake_timeout", 0, 1);
        AWVALID = 1'b0; WVALID = 1'b0;
        b_done = 1'b0;
        for (int c = 0; c < 20 && !b_done; c++) begin
            @(negedge ACLK);
            b_done = BVALID && BREADY;
            @(posedge ACLK); #1;
        end
        if (!b_done) chk("bvalid_timeout", 0, 1);
        chk("regs_o", regs_o, model_flat());
    endtask

    task automatic do_read(input logic [4:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        logic a, ar_done, r_done;
        r_q.push_back({exp_data, exp_resp});
        ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
        ar_done = 1'b0;
        for (int c = 0; c < 20 && !ar_done; c++) begin
            @(negedge ACLK);
            a = ARVALID && ARREADY;
            @(posedge ACLK); #1;
            if (a) begin ARVALID = 1'b0; ar_done = 1'b1; end
        end
        if (!ar_done) chk("ar_handshake_timeout", 0, 1);
        ARVALID = 1'b0;
        r_done = 1'b0;
        for (int c = 0; c < 20 && !r_done; c++) begin
            @(negedge ACLK);
            r_done = RVALID && RREADY;
            @(posedge ACLK); #1;
        end
        if (!r_done) chk("rvalid_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old_val;

        for (int k = 0; k < 4; k++) begin mdl[k] = '0; pulse_cnt[k] = 0; end

        vecs[0]  = mk(1'b1, 5'h00, 32'h0000_0001, 4'hF, 32'h0, 2'b00);
        vecs[1]  = mk(1'b1, 5'h04, 32'h0000_0002, 4'hF, 32'h0, 2'b00);
        vecs[2]  = mk(1'b1, 5'h08, 32'h0000_0003, 4'hF, 32'h0, 2'b00);
        vecs[3]  = mk(1'b1, 5'h0C, 32'h0000_0004, 4'hF, 32'h0, 2'b00);
        vecs[4]  = mk(1'b0, 5'h00, 32'h0, 4'h0, 32'h0000_0001, 2'b00);
        vecs[5]  = mk(1'b0, 5'h04, 32'h0, 4'h0, 32'h0000_0002, 2'b00);
        vecs[6]  = mk(1'b0, 5'h08, 32'h0, 4'h0, 32'h0000_0003, 2'b00);
        vecs[7]  = mk(1'b0, 5'h0C, 32'h0, 4'h0, 32'h0000_0004, 2'b00);
        vecs[8]  = mk(1'b1, 5'h00, 32'h1122_3344, 4'hF, 32'h0, 2'b00);
        vecs[9]  = mk(1'b1, 5'h00, 32'hAABB_CCDD, 4'b0101, 32'h0, 2'b00);
        vecs[10] = mk(1'b0, 5'h00, 32'h0, 4'h0, 32'h11BB_33DD, 2'b00);
        vecs[11] = mk(1'b1, 5'h10, 32'h0000_0055, 4'hF, 32'h0, UNMAP_RESP);
        vecs[12] = mk(1'b0, 5'h10, 32'h0, 4'h0, 32'h0000_0000, UNMAP_RESP);
        vecs[13] = mk(1'b0, 5'h04, 32'h0, 4'h0, 32'h0000_0002, 2'b00);
        vecs[14] = mk(1'b0, 5'h01, 32'h0, 4'h0, 32'h11BB_33DD, 2'b00);
        vecs[15] = mk(1'b1, 5'h0E, 32'h89AB_CDEF, 4'b1000, 32'h0, 2'b00);
        vecs[16] = mk(1'b0, 5'h0C, 32'h0, 4'h0, 32'h8900_0004, 2'b00);
        vecs[17] = mk(1'b1, 5'h1C, 32'hFFFF_FFFF, 4'hF, 32'h0, UNMAP_RESP);
        vecs[18] = mk(1'b0, 5'h08, 32'h0, 4'h0, 32'h0000_0003, 2'b00);

        // Reset state
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_awready", AWREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_arready", ARREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_bresp", BRESP, 0);
        chk("rst_rresp", RRESP, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_regs_o", regs_o, 0);
        chk("rst_wr_pulse", wr_pulse_o, 0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        chk("post_rst_awready", AWREADY, 1);
        chk("post_rst_wready", WREADY, 1);
        chk("post_rst_arready", ARREADY, 1);
        @(posedge ACLK); #1;

        // Vector table
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp);
            else            do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
            if (i == 3) begin
                for (int k = 0; k < 4; k++) chk($sformatf("wr_pulse_count%0d", k), pulse_cnt[k], 1);
            end
        end

        // W three cycles ahead of AW to slot 1
        $display("W  W-before-AW addr=04 data=deadbeef");
        b_q.push_back(2'b00);
        model_write(5'h04, 32'hDEAD_BEEF, 4'hF);
        BREADY = 1'b1; WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF; WVALID = 1'b1;
        @(negedge ACLK); chk("wready_pre", WREADY, 1);
        @(posedge ACLK); #1; WVALID = 1'b0;
        @(negedge ACLK); chk("wready_drop", WREADY, 0);
        @(posedge ACLK); #1;
        @(posedge ACLK); #1;
        AWADDR = 5'h04; AWVALID = 1'b1;
        @(negedge ACLK);
        chk("awready_pre", AWREADY, 1);
        chk("wready_hold", WREADY, 0);
        @(posedge ACLK); #1; AWVALID = 1'b0;
        @(negedge ACLK); chk("bvalid_one_cycle", BVALID, 0);
        @(posedge ACLK);
        @(negedge ACLK);
        chk("bvalid_two_cycle", BVALID, 1);
        chk("regs_slot1", regs_o[63:32], 32'hDEAD_BEEF);
        chk("wr_pulse_slot1", wr_pulse_o, 4'b0010);
        @(posedge ACLK);
        @(negedge ACLK);
        chk("bvalid_cleared", BVALID, 0);
        chk("wr_pulse_cleared", wr_pulse_o, 4'b0000);
        @(posedge ACLK); #1;

        // Backpressure, with a read colliding with the commit to slot 2
        BREADY = 1'b0; RREADY = 1'b0;
        old_val = mdl[2];
        b_q.push_back(2'b00);
        model_write(5'h08, 32'hCAFE_F00D, 4'hF);
        r_q.push_back({old_val, 2'b00});
        $display("W  stall addr=08 data=cafef00d with read of 08");
        AWADDR = 5'h08; AWVALID = 1'b1; WDATA = 32'hCAFE_F00D; WSTRB = 4'hF; WVALID = 1'b1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        ARADDR = 5'h08; ARVALID = 1'b1;
        @(negedge ACLK);
        chk("arready_pre", ARREADY, 1);
        chk("awready_busy", AWREADY, 0);
        @(posedge ACLK); #1; ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            chk("bvalid_hold", BVALID, 1);
            chk("rvalid_hold", RVALID, 1);
            chk("bresp_hold", BRESP, 2'b00);
            chk("rdata_hold", RDATA, 32'h0000_0003);
            chk("awready_stall", AWREADY, 0);
            chk("wready_stall", WREADY, 0);
            chk("arready_stall", ARREADY, 0);
        end
        @(posedge ACLK); #1;
        BREADY = 1'b1; RREADY = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        chk("awready_release", AWREADY, 1);
        chk("arready_release", ARREADY, 1);
        chk("bvalid_release", BVALID, 0);
        chk("rvalid_release", RVALID, 0);
        chk("regs_slot2", regs_o[95:64], 32'hCAFE_F00D);
        @(posedge ACLK); #1;
        do_read(5'h08, 32'hCAFE_F00D, 2'b00);

        // Reset between the AW and W handshakes
        $display("W  reset between AW and W");
        AWADDR = 5'h00; AWVALID = 1'b1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0; ARESET = 1'b1;
        #1;
        chk("midrst_bvalid", BVALID, 0);
        chk("midrst_regs_o", regs_o, 0);
        chk("midrst_awready", AWREADY, 0);
        for (int k = 0; k < 4; k++) mdl[k] = '0;
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            chk("midrst_no_commit", BVALID, 0);
            chk("midrst_regs_zero", regs_o, 0);
        end
        @(posedge ACLK); #1;
        do_write(5'h04, 32'h1234_5678, 4'hF, 2'b00);
        do_read(5'h04, 32'h1234_5678, 2'b00);
        do_read(5'h00, 32'h0000_0000, 2'b00);

        repeat (2) @(posedge ACLK);
        chk("b_queue_drained", b_q.size(), 0);
        chk("r_queue_drained", r_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_counter_axil_slave.md
# uart_counter_axil_slave

AXI4-Lite responder (slave register file) for the UART counter IP. It terminates the S00_AXI port that the AXI VIP master drives in the IP's example bench. It holds four 32-bit read/write registers at word offsets 0x0–0xC with byte-strobe support, and exposes them to the counter/UART core. Read and write channels are independent; each allows one outstanding transaction.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32: data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5: byte address width. Decodes 8 word slots; slots 0–3 are implemented.

Ports:
- ACLK  in  1  single clock for all logic.
- ARESET  in  1  asynchronous, active-high reset.
- AWADDR  in  5  write address; bits [4:2] select the slot, bits [1:0] are ignored.
- AWPROT  in  3  accepted and ignored.
- AWVALID / AWREADY  in / out  1 each  write address handshake.
- WDATA  in  32  write data.
- WSTRB  in  4  byte lane enables.
- WVALID / WREADY  in / out  1 each  write data handshake.
- BRESP  out  2  write response.
- BVALID / BREADY  out / in  1 each  write response handshake.
- ARADDR  in  5  read address.
- ARPROT  in  3  accepted and ignored.
- ARVALID / ARREADY  in / out  1 each  read address handshake.
- RDATA  out  32  read data.
- RRESP  out  2  read response.
- RVALID / RREADY  out / in  1 each  read data handshake.
- regs_o  out  128  concatenated register contents; slot n occupies [32n+31:32n].
- wr_pulse_o  out  4  one-cycle pulse per slot, asserted in the cycle after that slot is updated.

## Operation
- Write path:
  - aw_full and w_full flags latch AWADDR and WDATA/WSTRB independently, so AW and W may arrive in either order or in the same cycle.
  - AWREADY = !aw_full & !BVALID. WREADY = !w_full & !BVALID.
  - With aw_full & w_full both set, the commit cycle writes the enabled bytes (WSTRB[k] updates bits [8k+7:8k]) to the selected slot, clears both flags and sets BVALID.
  - BVALID holds, with BRESP stable, until BREADY. It clears on the handshake edge.
  - Slot 4–7 writes are discarded.
- Read path:
  - ARREADY = !RVALID.
  - On an AR handshake, RDATA is registered from the selected slot (slots 4–7 read 0) and RVALID is set.
  - RDATA, RRESP and RVALID hold until RREADY.
- A same-cycle read and commit to the same slot returns the old value.
- The write and read channels never stall each other.

## Timing
- Reset values: AWREADY=0, WREADY=0 while ARESET is high, then 1 on the first cycle after deassertion. ARREADY follows the same rule. BVALID=0, RVALID=0, BRESP=00, RRESP=00, RDATA=0, regs_o=0, wr_pulse_o=0. Flags are cleared.
- Write latency: AW and W handshake at edge E0 → commit at E1 → BVALID and new regs_o visible after E1. This is 2 cycles from the handshake cycle.
- If AW precedes W, the latency is measured from the later handshake.
- Read latency: AR handshake at E0 → RVALID high after E0 (1 cycle).
- Throughput: one write per 3 cycles and one read per 2 cycles with BREADY/RREADY held high.
- Reset asserted mid-transaction: all pending flags and valids clear immediately (asynchronous). In-flight transactions are dropped, and the registers return to 0.

## Configuration
- UART_CNT_AXIL_SLVERR_EN defined: accesses to slots 4–7 return BRESP/RRESP = 2'b10 (SLVERR). RDATA = 0, and no register changes.
- Macro undefined: all responses are OKAY (2'b00). Unmapped reads return 0 and unmapped writes are silently dropped.

## Test plan
- Write 0x1, 0x2, 0x3, 0x4 to 0x0/0x4/0x8/0xC, then read back → RDATA equals the written data, RRESP=00, and each wr_pulse_o bit fires once.
- W presented 3 cycles before AW to 0x4 (0xDEADBEEF) → WREADY drops after its handshake and BVALID rises 2 cycles after the AW handshake. regs_o[63:32]=0xDEADBEEF.
- Slot 0 preloaded with 0x11223344, then write 0xAABBCCDD with WSTRB=0101 → read returns 0x11BB33DD.
- BREADY and RREADY held low for 5 cycles → BVALID/RVALID, BRESP and RDATA stay stable. AWREADY, WREADY and ARREADY stay 0 until the respective handshake.
- Write 0x55 and read 0x10 → with UART_CNT_AXIL_SLVERR_EN the responses are BRESP=RRESP=10 and RDATA=0. Without it the responses are 00, and slots 0–3 are unchanged.
- ARESET pulsed high between the AW handshake and the W handshake → no commit, BVALID=0, regs_o=0, and a following complete write succeeds normally.
